// File: rtl/gpio_in_ctl_pkg.sv
// Shared definitions for the conditioned GPIO input port: register indices,
// reset constants and the pending/edge update helpers.
package gpio_in_ctl_pkg;

  typedef enum logic [1:0] {
    GPI_DATA = 2'd0,
    GPI_PEND = 2'd1,
    GPI_MASK = 2'd2,
    GPI_EDGE = 2'd3
  } gpi_reg_e;

  localparam logic [7:0] EDGE_RST  = 8'hFF;
  localparam logic [7:0] BYTE_ZERO = 8'h00;

  // Select rising or falling transitions of the debounced level per bit.
  function automatic logic [7:0] edge_events(input logic [7:0] db_cur,
                                             input logic [7:0] db_nxt,
                                             input logic [7:0] edg);
    logic [7:0] chg;
    chg = db_cur ^ db_nxt;
    return (chg & db_nxt & edg) | (chg & ~db_nxt & ~edg);
  endfunction

  // W1C clear first, then OR in new events so a same-cycle event is never lost.
  function automatic logic [7:0] pend_next(input logic [7:0] pnd,
                                           input logic [7:0] ev,
                                           input logic [7:0] clr);
    return (pnd & ~clr) | ev;
  endfunction

endpackage

// File: rtl/gpio_in_ctl_if.sv
// CPU-side register bus of the GPIO input port, including the level IRQ.
interface gpio_in_ctl_if;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;

  modport master (output cs, we, addr, din, input dout, irq);
  modport slave  (input cs, we, addr, din, output dout, irq);
endinterface

// File: rtl/gpio_in_debounce.sv
// One input bit: 2-FF synchroniser, tick-driven debounce counter and the clean
// level flop. db_nxt exposes the level the flop takes on the coming edge.
module gpio_in_debounce #(
  parameter int DB_CNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic pin,
  output logic db,
  output logic db_nxt
);

  localparam logic [3:0] CNT_LAST = 4'(DB_CNT - 1);

  logic       sync1_r;
  logic       sync2_r;
  logic [3:0] cnt_r;
  logic [3:0] cnt_nxt_s;
  logic       db_r;
  logic       db_nxt_s;

  // Debounce decision, evaluated only on prescaler ticks.
  always_comb begin
    cnt_nxt_s = cnt_r;
    db_nxt_s  = db_r;
    if (tick) begin
      if (sync2_r == db_r) begin
        cnt_nxt_s = 4'd0;
      end else if (cnt_r == CNT_LAST) begin
        db_nxt_s  = sync2_r;
        cnt_nxt_s = 4'd0;
      end else begin
        cnt_nxt_s = cnt_r + 4'd1;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Synchroniser, counter and level state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      cnt_r   <= 4'd0;
      db_r    <= 1'b0;
    end else begin
      sync1_r <= pin;
      sync2_r <= sync1_r;
      cnt_r   <= cnt_nxt_s;
      db_r    <= db_nxt_s;
    end
  end

  assign db     = db_r;
  assign db_nxt = db_nxt_s;

endmodule

// File: rtl/gpio_in_ctl.sv
// Conditioned 8-bit input port: shared debounce prescaler, per-bit conditioning,
// edge-to-pending latch, masked level IRQ and the CPU register file.
module gpio_in_ctl
  import gpio_in_ctl_pkg::*;
#(
  parameter int PRESCALE = 1200,
  parameter int DB_CNT   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    gpio_i,
  gpio_in_ctl_if.slave  bus
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] pre_r;
  logic [15:0] pre_nxt_s;
  logic        tick_s;
  logic [7:0]  db_s;
  logic [7:0]  db_nxt_s;
  logic [7:0]  ev_s;
  logic [7:0]  pnd_r;
  logic [7:0]  msk_r;
  logic [7:0]  edg_r;
  logic [7:0]  clr_s;
  logic [7:0]  msk_nxt_s;
  logic [7:0]  edg_nxt_s;
  logic [7:0]  rd_data_s;
  logic        rd_s;
  logic        wr_s;

  // Free-running prescaler; tick marks the wrap cycle.
  always_comb begin
    tick_s = (pre_r == PRE_LAST);
    if (tick_s) begin
      pre_nxt_s = 16'd0;
    end else begin
      pre_nxt_s = pre_r + 16'd1;
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_bit
    gpio_in_debounce #(.DB_CNT(DB_CNT)) u_db (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick_s),
      .pin    (gpio_i[g]),
      .db     (db_s[g]),
      .db_nxt (db_nxt_s[g])
    );
  end

  // Register decode; events are taken from the level change happening this edge.
  always_comb begin
    rd_s      = bus.cs & ~bus.we;
    wr_s      = bus.cs & bus.we;
    ev_s      = edge_events(db_s, db_nxt_s, edg_r);
    clr_s     = BYTE_ZERO;
    msk_nxt_s = msk_r;
    edg_nxt_s = edg_r;
    rd_data_s = BYTE_ZERO;
    case (gpi_reg_e'(bus.addr))
      GPI_DATA: rd_data_s = db_s;
      GPI_PEND: begin
        rd_data_s = pnd_r;
        if (wr_s) begin
          clr_s = bus.din;
        end else begin
          clr_s = BYTE_ZERO;
        end
      end
      GPI_MASK: begin
        rd_data_s = msk_r;
        if (wr_s) begin
          msk_nxt_s = bus.din;
        end else begin
          msk_nxt_s = msk_r;
        end
      end
      GPI_EDGE: begin
        rd_data_s = edg_r;
        if (wr_s) begin
          edg_nxt_s = bus.din;
        end else begin
          edg_nxt_s = edg_r;
        end
      end
      default: rd_data_s = BYTE_ZERO;
    endcase
  end

  // Control registers, read data and IRQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_r    <= 16'd0;
      pnd_r    <= BYTE_ZERO;
      msk_r    <= BYTE_ZERO;
      edg_r    <= EDGE_RST;
      bus.dout <= BYTE_ZERO;
      bus.irq  <= 1'b0;
    end else begin
      pre_r   <= pre_nxt_s;
      pnd_r   <= pend_next(pnd_r, ev_s, clr_s);
      msk_r   <= msk_nxt_s;
      edg_r   <= edg_nxt_s;
      bus.irq <= |(pnd_r & msk_r);
      if (rd_s) begin
        bus.dout <= rd_data_s;
      end else begin
        bus.dout <= bus.dout;
      end
    end
  end

endmodule

// File: tb/tb_gpio_in_ctl.sv
// Randomised and directed bench for gpio_in_ctl against a cycle-level behavioural model.
module tb_gpio_in_ctl;

  localparam int PRE = 4;
  localparam int DB  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] gpio_i;
  int         tests = 0;
  int         fails = 0;

  gpio_in_ctl_if bus_if ();

  gpio_in_ctl #(.PRESCALE(PRE), .DB_CNT(DB)) dut (
    .clk    (clk),
    .reset  (reset),
    .gpio_i (gpio_i),
    .bus    (bus_if.slave)
  );

  always #5 clk = ~clk;

  // Model state: pins seen at the last two edges, edges since reset, per-bit run of differing ticks.
  logic [7:0] m_h1, m_h2, m_db, m_pnd, m_msk, m_edg, m_dout;
  logic       m_irq;
  int         m_n;
  int         m_run [8];

  task automatic model_reset();
    m_h1 = 8'h00; m_h2 = 8'h00; m_n = 0;
    m_db = 8'h00; m_pnd = 8'h00; m_msk = 8'h00; m_edg = 8'hFF;
    m_dout = 8'h00; m_irq = 1'b0;
    for (int b = 0; b < 8; b++) m_run[b] = 0;
  endtask

  task automatic model_edge();
    logic [7:0] sync, ndb, chg, ev, clr;
    bit tick;
    sync = m_h2;
    m_n++;
    tick = (m_n % PRE) == 0;
    ndb = m_db;
    if (tick) begin
      for (int b = 0; b < 8; b++) begin
        if (sync[b] == m_db[b]) m_run[b] = 0;
        else begin
          m_run[b]++;
          if (m_run[b] == DB) begin
            ndb[b] = ~m_db[b];
            m_run[b] = 0;
          end
        end
      end
    end
    chg = ndb ^ m_db;
    ev  = (chg & ndb & m_edg) | (chg & ~ndb & ~m_edg);
    if (bus_if.cs && !bus_if.we) begin
      case (bus_if.addr)
        2'd0:    m_dout = m_db;
        2'd1:    m_dout = m_pnd;
        2'd2:    m_dout = m_msk;
        default: m_dout = m_edg;
      endcase
    end
    m_irq = |(m_pnd & m_msk);
    clr = (bus_if.cs && bus_if.we && bus_if.addr == 2'd1) ? bus_if.din : 8'h00;
    if (bus_if.cs && bus_if.we && bus_if.addr == 2'd2) m_msk = bus_if.din;
    if (bus_if.cs && bus_if.we && bus_if.addr == 2'd3) m_edg = bus_if.din;
    m_pnd = (m_pnd & ~clr) | ev;
    m_db  = ndb;
    m_h2  = m_h1;
    m_h1  = gpio_i;
  endtask

  function automatic bit flip_next(int b);
    return ((m_n + 1) % PRE == 0) && (m_run[b] == DB - 1) && (m_h2[b] != m_db[b]);
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pin both the DUT read data and the model to a hand-computed value.
  task automatic check_rd(string name, logic [7:0] exp);
    check(name, bus_if.dout, exp);
    check({name, "_model"}, m_dout, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic rd(logic [1:0] a);
    bus_if.cs = 1'b1; bus_if.we = 1'b0; bus_if.addr = a;
    cyc();
    bus_if.cs = 1'b0;
  endtask

  task automatic wr(logic [1:0] a, logic [7:0] d);
    bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.addr = a; bus_if.din = d;
    cyc();
    bus_if.cs = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_if.cs = 1'b0;
    model_reset();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Every-cycle comparison of the observable outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("dout", bus_if.dout, m_dout);
      check("irq", {7'd0, bus_if.irq}, {7'd0, m_irq});
    end
  end

  initial begin
    bit found;
    reset = 1'b1;
    gpio_i = 8'h00;
    bus_if.cs = 1'b0; bus_if.we = 1'b0; bus_if.addr = 2'd0; bus_if.din = 8'h00;
    model_reset();

    // 1: basic rising event, mask, W1C
    do_reset();
    check_rd("rst_dout", 8'h00);
    gpio_i = 8'h01;
    idle(13);
    rd(2'd0); check_rd("t1_data", 8'h01);
    rd(2'd1); check_rd("t1_pend", 8'h01);
    check("t1_irq_masked", {7'd0, bus_if.irq}, 8'h00);
    wr(2'd2, 8'h01);
    check("t1_irq_lag", {7'd0, bus_if.irq}, 8'h00);
    idle(1);
    check("t1_irq_on", {7'd0, bus_if.irq}, 8'h01);
    wr(2'd1, 8'h01);
    check("t1_irq_hold", {7'd0, bus_if.irq}, 8'h01);
    idle(1);
    check("t1_irq_off", {7'd0, bus_if.irq}, 8'h00);

    // 2: glitch shorter than DB ticks
    do_reset();
    wr(2'd2, 8'hFF);
    gpio_i = 8'h08;
    idle(8);
    gpio_i = 8'h00;
    idle(20);
    rd(2'd0); check_rd("t2_data", 8'h00);
    rd(2'd1); check_rd("t2_pend", 8'h00);
    check("t2_irq", {7'd0, bus_if.irq}, 8'h00);

    // 3: falling select on bit 7, rising on bit 6
    do_reset();
    wr(2'd3, 8'h7F);
    gpio_i = 8'h80;
    idle(16);
    rd(2'd0); check_rd("t3_data", 8'h80);
    wr(2'd1, 8'hFF);
    gpio_i = 8'h00;
    idle(16);
    rd(2'd1); check_rd("t3_pend_fall", 8'h80);
    gpio_i = 8'h40;
    idle(16);
    rd(2'd1); check_rd("t3_pend_rise", 8'hC0);

    // 4: W1C on the same edge as the bit-2 event
    do_reset();
    gpio_i = 8'h04;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (flip_next(2)) found = 1'b1;
      else cyc();
    end
    check("t4_found", {7'd0, found}, 8'h01);
    wr(2'd1, 8'hFF);
    rd(2'd1); check_rd("t4_pend", 8'h04);

    // 5: async reset mid-count on bit 5
    do_reset();
    gpio_i = 8'h01;
    idle(14);
    wr(2'd2, 8'hFF);
    idle(1);
    rd(2'd1); check_rd("t5_pre_pend", 8'h01);
    check("t5_pre_irq", {7'd0, bus_if.irq}, 8'h01);
    gpio_i = 8'h21;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_run[5] == 2) found = 1'b1;
      else cyc();
    end
    check("t5_midcount", {7'd0, found}, 8'h01);
    reset = 1'b1;
    model_reset();
    #1;
    check("t5_dout_now", bus_if.dout, 8'h00);
    check("t5_irq_now", {7'd0, bus_if.irq}, 8'h00);
    cyc();
    cyc();
    reset = 1'b0;
    idle(10);
    rd(2'd0); check_rd("t5_data_early", 8'h00);
    idle(1);
    rd(2'd0); check_rd("t5_data_late", 8'h21);
    rd(2'd3); check_rd("t5_edge", 8'hFF);
    rd(2'd2); check_rd("t5_mask", 8'h00);

    // 6: pins held high through reset
    gpio_i = 8'hA5;
    do_reset();
    idle(13);
    rd(2'd0); check_rd("t6_data", 8'hA5);
    rd(2'd1); check_rd("t6_pend", 8'hA5);
    check("t6_irq_off", {7'd0, bus_if.irq}, 8'h00);
    wr(2'd2, 8'hFF);
    idle(1);
    check("t6_irq_on", {7'd0, bus_if.irq}, 8'h01);

    // Random traffic with one reset in the middle
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) gpio_i = gpio_i ^ 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        bus_if.cs   = 1'b1;
        bus_if.we   = 1'($urandom);
        bus_if.addr = 2'($urandom);
        bus_if.din  = 8'($urandom);
      end else begin
        bus_if.cs = 1'b0;
      end
      if (i == 1500) begin
        reset = 1'b1;
        model_reset();
        cyc();
        reset = 1'b0;
      end else begin
        cyc();
      end
    end
    bus_if.cs = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpio_in_ctl.md
Name: gpio_in_ctl

Overview:
- Conditioned 8-bit input port peripheral on the 6502 data bus, instantiated inside tst_6502 alongside the gpio_o output register.
- Per input bit: 2-FF synchroniser, then debounce, then edge detection.
- Edge events latch into a pending register, and a masked OR drives a level IRQ to the CPU.
- Firmware reads the clean levels, acks events and selects the edge polarity.

Parameters:
PRESCALE, 1200, clk cycles per debounce sample tick (100 us at 12 MHz); legal range 2..65535
DB_CNT, 4, consecutive differing ticks required to accept a new level; legal range 2..15

Ports:
clk  input  1  system clock (12 MHz in the up5k build)
reset  input  1  asynchronous, active-high reset
cs  input  1  register select, one-cycle strobe qualified by the CPU
we  input  1  1 = write, 0 = read (valid with cs)
addr  input  2  register index
din  input  8  write data
dout  output  8  read data, registered
gpio_i  input  8  raw asynchronous pins
irq  output  1  level interrupt request, active high

Behaviour:
- Async reset values:
  - sync FFs, debounced (DB) = 0x00, pending (PND) = 0x00, mask (MSK) = 0x00
  - edge select (EDG) = 0xFF (rising), all debounce counters = 0, prescaler = 0
  - dout = 0x00, irq = 0
- Synchroniser: 2 FFs per bit. A pin change is visible at the sync output 2 clk later.
- Prescaler:
  - Free-running counter, 0..PRESCALE-1.
  - tick = 1 for one clk when the count is PRESCALE-1; the count wraps to 0 on that cycle.
  - First tick occurs PRESCALE cycles after reset deasserts.
- Debounce, per bit i, on each tick:
  - If sync[i] == DB[i]: cnt[i] <= 0.
  - Else if cnt[i] == DB_CNT-1: DB[i] <= sync[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Counters change only on ticks.
  - A glitch shorter than DB_CNT ticks never changes DB.
  - Latency from pin change to DB: between 2+(DB_CNT-1)*PRESCALE+1 and 2+DB_CNT*PRESCALE clk.
- Edge detect:
  - rise[i] = DB[i] going 0->1; fall[i] = DB[i] going 1->0.
  - ev[i] = EDG[i] ? rise[i] : fall[i].
  - An event sets PND[i] on the same edge DB updates.
- Register map:
  - 0 DATA: read DB; writes ignored.
  - 1 PEND: read PND; write-1-to-clear.
  - 2 MASK: read/write.
  - 3 EDGE: read/write, 1 = rising, 0 = falling.
- Simultaneous event and W1C clear on the same bit in the same cycle: set wins, so PND[i] stays 1.
- Read timing:
  - When cs & ~we, dout <= selected register on that clk edge, so data is valid the next cycle.
  - dout holds otherwise.
  - A read of PND captures the pre-update value; a set in the same cycle is visible on the next read.
- irq:
  - Registered: irq <= |(PND & MSK), so it follows PND/MSK changes by 1 clk.
  - It stays asserted until firmware clears the pending bit or masks it.
- Writes to EDGE take effect for events from the next clk on. Changing EDGE never creates an event by itself.
- Post-reset behaviour: an input held high at reset produces DB 0->1 after DB_CNT ticks. This sets PND with default EDG; the IRQ stays silent because MSK = 0. Firmware clears PEND before unmasking.
- Reset asserted mid-debounce or mid-transaction: all state returns to reset values immediately. An in-flight write is dropped.

Decomposition:
- Shared package holds:
  - register index constants: GPI_DATA = 2'd0, GPI_PEND = 2'd1, GPI_MASK = 2'd2, GPI_EDGE = 2'd3
  - reset constants: EDGE_RST = 8'hFF
- One sub-module, gpio_in_debounce:
  - a single-bit synchroniser, counter and DB flop, driven by the shared tick
  - instantiated 8 times from a generate loop
- Prescaler, registers, edge logic and IRQ stay in gpio_in_ctl.

Test Plan (bench uses PRESCALE=4, DB_CNT=3):
1. Reset with gpio_i=0x00, then drive gpio_i=0x01 -> DATA reads 0x01 within 2+12 clk; PEND=0x01; irq=0 (MSK=0). Write MASK=0x01 -> irq=1 the cycle after MSK updates. Write PEND=0x01 -> PND=0x00, irq=0 one clk after the clear.
2. Glitch: pulse gpio_i[3] high for 8 clk (< 3 ticks) -> DATA stays 0x00, PEND stays 0x00, irq stays 0.
3. Falling select: write EDGE=0x7F, hold gpio_i[7]=1 until DB=0x80, clear PEND, then drop to 0 -> PEND=0x80. Rising on bit 6 -> PEND bit 6 set only if EDGE[6]=1.
4. Race: align a PEND=0xFF write with the DB update clk of bit 2 -> PEND reads 0x04 afterwards.
5. Async reset asserted mid-debounce, mid-count on bit 5 -> dout, irq, PND, MSK, DB are 0 immediately and EDG=0xFF. After release, the bit needs a full 3 fresh ticks to update.
6. Post-reset with gpio_i=0xA5 held -> after ~14 clk DATA=0xA5, PEND=0xA5, irq=0. Write MASK=0xFF -> irq=1.
